// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the pipeline controller and mul_div_unit.
// The controller is the master; the unit is the slave.
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, A, B,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, A, B,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning HI/LO: one shift-add or
// restoring-divide step per cycle, then a sign-fix cycle.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input logic           clk,
    input logic           rst,
    mul_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam int W2 = 2 * WIDTH;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic             res_neg_q, res_neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             dz_q, dz_d;
    logic             is_div_q, is_div_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             sgn;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
    logic [W2-1:0]    prod_fix;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;
    logic             last;

    assign sgn   = ~bus.op[0];
    assign a_abs = (sgn && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    assign b_abs = (sgn && bus.B[WIDTH-1]) ? -bus.B : bus.B;
    assign last  = (cnt_q == CW'(WIDTH - 1));

    // acc = {partial product high half, remaining multiplier bits}
    assign mul_sum = acc_q[0]
        ? {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, opnd_q}
        : {1'b0, acc_q[W2-1:WIDTH]};

    // acc = {partial remainder, dividend bits becoming quotient bits}
    assign div_shift = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, opnd_q};

    assign prod_fix = res_neg_q ? -acc_q : acc_q;
    assign quot_fix = res_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = rem_neg_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        res_neg_d = res_neg_q;
        rem_neg_d = rem_neg_q;
        dz_d      = dz_q;
        is_div_d  = is_div_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU: begin
                            state_d   = MUL;
                            busy_d    = 1'b1;
                            cnt_d     = '0;
                            is_div_d  = 1'b0;
                            opnd_d    = a_abs;
                            acc_d     = {{WIDTH{1'b0}}, b_abs};
                            res_neg_d = sgn & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                            rem_neg_d = sgn & bus.A[WIDTH-1];
                            dz_d      = 1'b0;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d   = DIV;
                            busy_d    = 1'b1;
                            cnt_d     = '0;
                            is_div_d  = 1'b1;
                            opnd_d    = b_abs;
                            acc_d     = {{WIDTH{1'b0}}, a_abs};
                            res_neg_d = sgn & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                            rem_neg_d = sgn & bus.A[WIDTH-1];
                            dz_d      = (bus.B == '0);
                        end
                        OP_MTHI: hi_d = bus.A;
                        OP_MTLO: lo_d = bus.A;
                        default: ;
                    endcase
                end
            end
            MUL: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (last) state_d = FIX;
            end
            DIV: begin
                if (!div_trial[WIDTH])
                    acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                else
                    acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + CW'(1);
                if (last) state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                cnt_d   = '0;
                if (is_div_q) begin
                    // remainder path already yields the raw dividend on /0
                    hi_d = rem_fix;
                    lo_d = dz_q ? {WIDTH{1'b1}} : quot_fix;
                end else begin
                    hi_d = prod_fix[W2-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            is_div_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            res_neg_q <= res_neg_d;
            rem_neg_q <= rem_neg_d;
            dz_q      <= dz_d;
            is_div_q  <= is_div_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: results, latency, MTHI/MTLO,
// ignored starts while busy, back-to-back issue and async reset.
module tb_mul_div_unit;
    localparam int W = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_NOP   = 3'b110;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    mul_div_unit_if #(.WIDTH(W)) bus ();

    mul_div_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Called at a negedge; request is accepted at the next posedge (E0).
    task automatic start_op(input logic [2:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = 32'h5A5A_A5A5;
        bus.B     = 32'hC3C3_3C3C;
    endtask

    task automatic wait_done(input string name, input logic [W-1:0] exp_hi,
                             input logic [W-1:0] exp_lo, input bit inj,
                             input logic [2:0] inj_op);
        logic [W-1:0] hold_hi;
        logic [W-1:0] hold_lo;
        int           cycles;
        hold_hi = bus.hi;
        hold_lo = bus.lo;
        cycles  = 0;
        while (bus.busy === 1'b1 && cycles < 100) begin
            if (cycles == 5 && inj) begin
                bus.start = 1'b1;
                bus.op    = inj_op;
                bus.A     = 32'hDEAD_BEEF;
                bus.B     = 32'h0000_0003;
            end
            if (cycles == 6) bus.start = 1'b0;
            if (cycles == 10) begin
                chk({name, " hold_hi"}, bus.hi, hold_hi);
                chk({name, " hold_lo"}, bus.lo, hold_lo);
            end
            @(negedge clk);
            cycles++;
        end
        chk({name, " busy_cycles"}, W'(cycles), W'(33));
        chk({name, " done"}, {31'd0, bus.done}, 32'd1);
        chk({name, " hi"}, bus.hi, exp_hi);
        chk({name, " lo"}, bus.lo, exp_lo);
    endtask

    task automatic run_op(input string name, input logic [2:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_hi,
                          input logic [W-1:0] exp_lo);
        start_op(op, a, b);
        chk({name, " busy_at_e0"}, {31'd0, bus.busy}, 32'd1);
        wait_done(name, exp_hi, exp_lo, 1'b0, OP_NOP);
        @(negedge clk);
        chk({name, " done_drop"}, {31'd0, bus.done}, 32'd0);
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = OP_NOP;
        bus.A     = '0;
        bus.B     = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", {31'd0, bus.busy}, 32'd0);
        chk("reset done", {31'd0, bus.done}, 32'd0);
        chk("reset hi", bus.hi, 32'd0);
        chk("reset lo", bus.lo, 32'd0);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mult();
        run_op("mult", OP_MULT, 32'hFFFF_FFFD, 32'd5,
               32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001);
    endtask

    task automatic test_div();
        run_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_negb", OP_DIV, 32'd7, 32'hFFFF_FFFE,
               32'd1, 32'hFFFF_FFFD);
        run_op("divu", OP_DIVU, 32'hFFFF_FFF9, 32'd2,
               32'd1, 32'h7FFF_FFFC);
    endtask

    task automatic test_div_zero();
        run_op("divu0", OP_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
        run_op("div0", OP_DIV, 32'hFFFF_FFF9, 32'd0,
               32'hFFFF_FFF9, 32'hFFFF_FFFF);
    endtask

    task automatic test_overflow();
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
               32'd0, 32'h8000_0000);
    endtask

    task automatic test_mthi_mtlo();
        logic [W-1:0] old_lo;
        old_lo = bus.lo;
        bus.start = 1'b1;
        bus.op    = OP_MTHI;
        bus.A     = 32'h1234_5678;
        @(negedge clk);
        bus.start = 1'b0;
        chk("mthi hi", bus.hi, 32'h1234_5678);
        chk("mthi lo", bus.lo, old_lo);
        chk("mthi busy", {31'd0, bus.busy}, 32'd0);
        chk("mthi done", {31'd0, bus.done}, 32'd0);
        bus.start = 1'b1;
        bus.op    = OP_MTLO;
        bus.A     = 32'h9ABC_DEF0;
        @(negedge clk);
        bus.start = 1'b0;
        chk("mtlo lo", bus.lo, 32'h9ABC_DEF0);
        chk("mtlo hi", bus.hi, 32'h1234_5678);
        bus.start = 1'b1;
        bus.op    = OP_NOP;
        bus.A     = 32'hFFFF_0000;
        @(negedge clk);
        bus.start = 1'b0;
        chk("nop hi", bus.hi, 32'h1234_5678);
        chk("nop lo", bus.lo, 32'h9ABC_DEF0);
        chk("nop busy", {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic test_back_to_back();
        start_op(OP_MULTU, 32'd3, 32'd4);
        wait_done("b2b_mul", 32'd0, 32'd12, 1'b1, OP_MTLO);
        start_op(OP_DIV, 32'd10, 32'd3);
        chk("b2b busy", {31'd0, bus.busy}, 32'd1);
        chk("b2b done_drop", {31'd0, bus.done}, 32'd0);
        wait_done("b2b_div", 32'd1, 32'd3, 1'b1, OP_MULT);
        @(negedge clk);
        chk("b2b idle", {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic test_rst_mid();
        int pulses;
        start_op(OP_DIV, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst busy", {31'd0, bus.busy}, 32'd0);
        chk("arst done", {31'd0, bus.done}, 32'd0);
        chk("arst hi", bus.hi, 32'd0);
        chk("arst lo", bus.lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) pulses++;
        end
        chk("arst no_done", W'(pulses), 32'd0);
        chk("arst lo_kept", bus.lo, 32'd0);
        run_op("restart", OP_DIV, 32'd100, 32'd7, 32'd2, 32'd14);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_overflow();
        test_mthi_mtlo();
        test_back_to_back();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
